// File: rtl/if_pkg.sv
// Shared definitions for the fetch-to-decode instruction queue.
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
//
// Packet layout on the fetch-to-decode bus (MSB first):
//   adef | tlb_ex | tlb_ecode[5:0] | tlb_esubcode[8:0] | wrong_addr[31:0] | pc[31:0] | inst[31:0]
package if_pkg;

  localparam int IF_ID_BUS_W  = 113;
  localparam int IF_ID_DEPTH  = 4;

  // LSB offsets of each field within the packet.
  localparam int INST_LSB         = 0;
  localparam int PC_LSB           = 32;
  localparam int WRONG_ADDR_LSB   = 64;
  localparam int TLB_ESUBCODE_LSB = 96;
  localparam int TLB_ECODE_LSB    = 105;
  localparam int TLB_EX_BIT       = 111;
  localparam int ADEF_BIT         = 112;

  // Extracts the PC field from a packet.
  function automatic logic [31:0] pkt_pc(input logic [IF_ID_BUS_W-1:0] pkt);
    return pkt[PC_LSB +: 32];
  endfunction

endpackage

// File: rtl/queue_ram.sv
// Packet storage for the instruction queue: DEPTH x BUS_W register array.
// Latency: write visible on the read port the cycle after the write edge; read is combinational.
// Backpressure: none; write enable and addresses are owned by the control logic.
//
// Ports: clk, wr_en/wr_addr/wr_data (synchronous write), rd_addr/rd_data (asynchronous read).
module queue_ram #(
  parameter int DEPTH = 4,
  parameter int BUS_W = 113,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [BUS_W-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [BUS_W-1:0] rd_data
);

  // Contents are don't-care after reset, so the array carries no reset.
  logic [BUS_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/if_id_queue.sv
// Decoupling FIFO between fetch and decode; flushed on any pipeline redirect.
// Latency: 1 cycle push-to-head; 0 cycles when empty with IF_ID_QUEUE_BYPASS_EN defined.
// Backpressure: in_allowin drops when full, from registered count only (no path from out_allowin).
//
// Ports: clk, resetn (async active-low), in_valid/in_allowin/in_bus from fetch,
//        out_valid/out_allowin/out_bus to decode, flush (redirect), occupancy (entry count).
// Optional feature macro: IF_ID_QUEUE_BYPASS_EN (empty-queue combinational forwarding).
module if_id_queue
  import if_pkg::*;
#(
  parameter int DEPTH = IF_ID_DEPTH,
  parameter int BUS_W = IF_ID_BUS_W
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     in_valid,
  output logic                     in_allowin,
  input  logic [BUS_W-1:0]         in_bus,
  output logic                     out_valid,
  input  logic                     out_allowin,
  output logic [BUS_W-1:0]         out_bus,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [BUS_W-1:0] rd_data;

  logic empty, full;
  logic byp;        // head is the incoming packet, not a stored entry
  logic push, pop;
  logic wr_en;      // push that actually lands in storage
  logic rd_adv;     // pop that consumes a stored entry
  logic out_valid_i;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  always_comb begin
    byp = 1'b0;
`ifdef IF_ID_QUEUE_BYPASS_EN
    byp = empty & in_valid & ~flush;
`endif
  end

  assign in_allowin  = ~full;
  assign out_valid_i = (~empty & ~flush) | byp;
  assign out_valid   = out_valid_i;
  // Empty head reads as zero so out_bus is defined out of reset.
  assign out_bus     = byp ? in_bus : (empty ? '0 : rd_data);
  assign occupancy   = count_q;

  assign push   = in_valid & ~full & ~flush;
  assign pop    = out_valid_i & out_allowin;
  // A bypassed packet taken by decode in the same cycle never touches storage.
  assign wr_en  = push & ~(byp & out_allowin);
  assign rd_adv = pop & ~empty;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en)  wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_adv) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_en, rd_adv})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  queue_ram #(
    .DEPTH (DEPTH),
    .BUS_W (BUS_W),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en & ~flush),
    .wr_addr (wr_ptr_q),
    .wr_data (in_bus),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue against a queue-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_if_id_queue;
  import if_pkg::*;

  localparam int DEPTH = IF_ID_DEPTH;
  localparam int BW    = IF_ID_BUS_W;

  logic          clk = 1'b0;
  logic          resetn;
  logic          in_valid;
  logic          in_allowin;
  logic [BW-1:0] in_bus;
  logic          out_valid;
  logic          out_allowin;
  logic [BW-1:0] out_bus;
  logic          flush;
  logic [2:0]    occupancy;

  int total = 0;
  int bad   = 0;

  // Reference: the queue holds exactly the packets decode has yet to see, oldest first.
  logic [BW-1:0] model_q [$];

  if_id_queue dut (
    .clk         (clk),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_allowin  (in_allowin),
    .in_bus      (in_bus),
    .out_valid   (out_valid),
    .out_allowin (out_allowin),
    .out_bus     (out_bus),
    .flush       (flush),
    .occupancy   (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] mk_pkt(input logic [31:0] pc);
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    r[PC_LSB +: 32] = pc;
    return r[BW-1:0];
  endfunction

  // One clock cycle, entered and left at a falling edge: drive, check, then advance the model.
  task automatic cyc(input logic v, input logic [BW-1:0] b, input logic oa, input logic fl,
                     input string tag);
    int            n;
    logic          e_allow, e_ov, e_byp;
    logic [BW-1:0] e_bus;
    in_valid    = v;
    in_bus      = b;
    out_allowin = oa;
    flush       = fl;
    n       = model_q.size();
    e_allow = (n != DEPTH);
    e_byp   = 1'b0;
`ifdef IF_ID_QUEUE_BYPASS_EN
    e_byp   = (n == 0) && v && !fl;
`endif
    e_ov    = ((n != 0) && !fl) || e_byp;
    e_bus   = e_byp ? b : ((n != 0) ? model_q[0] : '0);
    #1;
    chk({tag, ".in_allowin"}, 128'(in_allowin), 128'(e_allow));
    chk({tag, ".out_valid"},  128'(out_valid),  128'(e_ov));
    chk({tag, ".occupancy"},  128'(occupancy),  128'(n));
    if (e_ov) chk({tag, ".out_bus"}, 128'(out_bus), 128'(e_bus));
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else if (e_byp) begin
      if (!oa) model_q.push_back(b);
    end else begin
      if (e_ov && oa) void'(model_q.pop_front());
      if (v && e_allow) model_q.push_back(b);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [BW-1:0] pend;
    resetn      = 1'b0;
    in_valid    = 1'b0;
    in_bus      = '0;
    out_allowin = 1'b0;
    flush       = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.in_allowin", 128'(in_allowin), 128'(1));
    chk("rst.out_valid",  128'(out_valid),  128'(0));
    chk("rst.occupancy",  128'(occupancy),  128'(0));
    chk("rst.out_bus",    128'(out_bus),    128'(0));
    @(negedge clk);
    resetn = 1'b1;

    // Streaming with decode always ready.
    cyc(1'b1, mk_pkt(32'h1c000000), 1'b1, 1'b0, "s0");
    cyc(1'b1, mk_pkt(32'h1c000004), 1'b1, 1'b0, "s1");
    cyc(1'b1, mk_pkt(32'h1c000008), 1'b1, 1'b0, "s2");
    cyc(1'b0, '0, 1'b1, 1'b0, "s3");
    cyc(1'b0, '0, 1'b1, 1'b0, "s4");

    // Fill to full with decode stalled; fifth packet is held by fetch.
    for (int i = 0; i < 4; i++) cyc(1'b1, mk_pkt(32'h1c000100 + 4 * i), 1'b0, 1'b0, "fill");
    pend = mk_pkt(32'h1c000110);
    cyc(1'b1, pend, 1'b0, 1'b0, "full_hold");
    cyc(1'b1, pend, 1'b1, 1'b0, "full_pop");
    cyc(1'b1, pend, 1'b0, 1'b0, "full_reenter");
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0, "drain");
    cyc(1'b0, '0, 1'b1, 1'b0, "empty");

    // Flush with three entries and a packet on offer, then back-to-back flushes.
    for (int i = 0; i < 3; i++) cyc(1'b1, mk_pkt(32'h1c000200 + 4 * i), 1'b0, 1'b0, "pf");
    cyc(1'b1, mk_pkt(32'h1c0002f0), 1'b1, 1'b1, "flush");
    cyc(1'b1, mk_pkt(32'h1c0002f4), 1'b1, 1'b1, "flush2");
    cyc(1'b0, '0, 1'b1, 1'b0, "post_flush");

    // Steady state at count 2 with simultaneous push and pop across the pointer wrap.
    cyc(1'b1, mk_pkt(32'h1c000300), 1'b0, 1'b0, "c2a");
    cyc(1'b1, mk_pkt(32'h1c000304), 1'b0, 1'b0, "c2b");
    for (int i = 0; i < 10; i++) cyc(1'b1, mk_pkt(32'h1c000308 + 4 * i), 1'b1, 1'b0, "pp");
    cyc(1'b0, '0, 1'b1, 1'b0, "pp_d0");
    cyc(1'b0, '0, 1'b1, 1'b0, "pp_d1");

    // Asynchronous reset with three entries, well before the next rising edge.
    for (int i = 0; i < 3; i++) cyc(1'b1, mk_pkt(32'h1c000400 + 4 * i), 1'b0, 1'b0, "ar");
    in_valid = 1'b0;
    #2;
    resetn = 1'b0;
    model_q.delete();
    #1;
    chk("arst.occupancy",  128'(occupancy),  128'(0));
    chk("arst.out_valid",  128'(out_valid),  128'(0));
    chk("arst.in_allowin", 128'(in_allowin), 128'(1));
    @(negedge clk);
    resetn = 1'b1;
    cyc(1'b0, '0, 1'b1, 1'b0, "post_arst");

`ifdef IF_ID_QUEUE_BYPASS_EN
    cyc(1'b1, mk_pkt(32'h1c000010), 1'b1, 1'b0, "byp");
    cyc(1'b0, '0, 1'b1, 1'b0, "byp_after");
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), mk_pkt($urandom), 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 19) == 0), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
